// File: rtl/key_conditioner_if.sv
// Key conditioner port bundle: raw key inputs from the board side and the
// conditioned level / pulse outputs toward the counter core.
interface key_conditioner_if #(
  parameter int N_KEYS = 6
);
  logic [N_KEYS-1:0] key_in;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_rep;

  // Board / stimulus side: drives raw keys, observes conditioned outputs.
  modport master (
    output key_in,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_rep
  );

  // Conditioner side.
  modport slave (
    input  key_in,
    output key_level,
    output key_press,
    output key_release,
    output key_rep
  );
endinterface

// File: rtl/key_conditioner.sv
// Key conditioner: per-channel 2-flop synchroniser, counter debounce,
// registered level / press / release outputs and an auto-repeat FSM on the
// channels selected by REPEAT_MASK. All outputs are registered.
module key_conditioner #(
  parameter int              N_KEYS          = 6,
  parameter int              ACTIVE_LOW      = 1,
  parameter int              DB_TICKS        = 1_000_000,
  parameter int              REP_DELAY_TICKS = 25_000_000,
  parameter int              REP_RATE_TICKS  = 5_000_000,
  parameter logic [N_KEYS-1:0] REPEAT_MASK   = N_KEYS'(6'b111000)
) (
  input  logic             CLK,
  input  logic             clr,
  key_conditioner_if.slave kif
);

  localparam int REP_MAX = (REP_DELAY_TICKS > REP_RATE_TICKS) ? REP_DELAY_TICKS : REP_RATE_TICKS;
  localparam int DBW     = $clog2(DB_TICKS);
  localparam int TW      = $clog2(REP_MAX);

  localparam logic [DBW-1:0]    DB_LAST    = DBW'(DB_TICKS - 1);
  localparam logic [TW-1:0]     DELAY_LAST = TW'(REP_DELAY_TICKS - 1);
  localparam logic [TW-1:0]     RATE_LAST  = TW'(REP_RATE_TICKS - 1);
  localparam logic [N_KEYS-1:0] INV_MASK   = (ACTIVE_LOW != 0) ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } rep_state_t;

  logic [N_KEYS-1:0] p_raw;
  logic [N_KEYS-1:0] sync1_reg;
  logic [N_KEYS-1:0] p_sync_reg;
  logic [N_KEYS-1:0] stable;
  logic [N_KEYS-1:0] stable_d_reg;
  logic [N_KEYS-1:0] press_now;
  logic [N_KEYS-1:0] release_now;
  logic [N_KEYS-1:0] rep_next;
  logic [N_KEYS-1:0] level_reg;
  logic [N_KEYS-1:0] press_reg;
  logic [N_KEYS-1:0] release_reg;
  logic [N_KEYS-1:0] rep_reg;

  // Normalise polarity so that 1 always means "pressed" internally.
  assign p_raw = kif.key_in ^ INV_MASK;

  // Two-flop synchroniser; reset loads the released level so a key held
  // through reset is seen as a fresh press afterwards.
  always_ff @(posedge CLK or posedge clr) begin
    if (clr) begin
      sync1_reg  <= '0;
      p_sync_reg <= '0;
    end else begin
      sync1_reg  <= p_raw;
      p_sync_reg <= sync1_reg;
    end
  end

  // Edge detection works on the debounced level against its one-cycle delay.
  assign press_now   = stable & ~stable_d_reg;
  assign release_now = ~stable & stable_d_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_KEYS; gi++) begin : g_ch
      logic [DBW-1:0] db_cnt_reg;
      logic           stable_reg;

      // Debounce: accept a new level only after DB_TICKS consecutive cycles
      // of disagreement; any return to the stable value restarts the count.
      always_ff @(posedge CLK or posedge clr) begin
        if (clr) begin
          db_cnt_reg <= '0;
          stable_reg <= 1'b0;
        end else if (p_sync_reg[gi] == stable_reg) begin
          db_cnt_reg <= '0;
        end else if (db_cnt_reg == DB_LAST) begin
          stable_reg <= p_sync_reg[gi];
          db_cnt_reg <= '0;
        end else begin
          db_cnt_reg <= db_cnt_reg + DBW'(1);
        end
      end

      assign stable[gi] = stable_reg;

      if (REPEAT_MASK[gi]) begin : g_rep
        rep_state_t    state_reg, state_next;
        logic [TW-1:0] timer_reg, timer_next;
        logic          rep_ch;

        // Repeat FSM state and timer registers.
        always_ff @(posedge CLK or posedge clr) begin
          if (clr) begin
            state_reg <= ST_IDLE;
            timer_reg <= '0;
          end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
          end
        end

        // Repeat FSM next state: pulse on press, after the initial delay and
        // then every rate period; a release wins over a same-cycle expiry.
        always_comb begin
          state_next = state_reg;
          timer_next = timer_reg;
          rep_ch     = 1'b0;
          case (state_reg)
            ST_IDLE: begin
              if (press_now[gi]) begin
                rep_ch     = 1'b1;
                timer_next = '0;
                state_next = ST_DELAY;
              end
            end
            ST_DELAY: begin
              if (!stable[gi]) begin
                timer_next = '0;
                state_next = ST_IDLE;
              end else if (timer_reg == DELAY_LAST) begin
                rep_ch     = 1'b1;
                timer_next = '0;
                state_next = ST_REPEAT;
              end else begin
                timer_next = timer_reg + TW'(1);
              end
            end
            ST_REPEAT: begin
              if (!stable[gi]) begin
                timer_next = '0;
                state_next = ST_IDLE;
              end else if (timer_reg == RATE_LAST) begin
                rep_ch     = 1'b1;
                timer_next = '0;
              end else begin
                timer_next = timer_reg + TW'(1);
              end
            end
            default: begin
              timer_next = '0;
              state_next = ST_IDLE;
            end
          endcase
        end

        assign rep_next[gi] = rep_ch;
      end else begin : g_norep
        assign rep_next[gi] = press_now[gi];
      end
    end
  endgenerate

  // Registered outputs; level and pulses change on the same clock edge.
  always_ff @(posedge CLK or posedge clr) begin
    if (clr) begin
      stable_d_reg <= '0;
      level_reg    <= '0;
      press_reg    <= '0;
      release_reg  <= '0;
      rep_reg      <= '0;
    end else begin
      stable_d_reg <= stable;
      level_reg    <= stable;
      press_reg    <= press_now;
      release_reg  <= release_now;
      rep_reg      <= rep_next;
    end
  end

  assign kif.key_level   = level_reg;
  assign kif.key_press   = press_reg;
  assign kif.key_release = release_reg;
  assign kif.key_rep     = rep_reg;

endmodule

// File: tb/tb_key_conditioner.sv
// Testbench for key_conditioner with short tick parameters
// (DB=4, delay=20, rate=5, active-low keys, repeat on channels 5..3).
module tb_key_conditioner;
  localparam int NK = 6;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   cyc = 0;

  key_conditioner_if #(.N_KEYS(NK)) kif ();

  key_conditioner #(
    .N_KEYS(NK),
    .ACTIVE_LOW(1),
    .DB_TICKS(4),
    .REP_DELAY_TICKS(20),
    .REP_RATE_TICKS(5),
    .REPEAT_MASK(6'b111000)
  ) dut (
    .CLK(clk),
    .clr(clr),
    .kif(kif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event log: kind 0=press 1=release 2=rep 3=level rise 4=level fall
  typedef struct {
    int cyc;
    int ch;
    int kind;
  } ev_t;

  ev_t evq[$];
  logic [NK-1:0] prev_level = '0;

  always @(negedge clk) begin
    ev_t e;
    for (int i = 0; i < NK; i++) begin
      e.cyc = cyc;
      e.ch  = i;
      if (kif.key_press[i])   begin e.kind = 0; evq.push_back(e); end
      if (kif.key_release[i]) begin e.kind = 1; evq.push_back(e); end
      if (kif.key_rep[i])     begin e.kind = 2; evq.push_back(e); end
      if (kif.key_level[i] && !prev_level[i]) begin e.kind = 3; evq.push_back(e); end
      if (!kif.key_level[i] && prev_level[i]) begin e.kind = 4; evq.push_back(e); end
    end
    prev_level = kif.key_level;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Compare the logged events of one kind on one channel against offsets from t0.
  task automatic check_kind(input string nm, input int ch, input int t0, input int kind,
                            input int exp_n, input int exp_offs[12]);
    int act[$];
    foreach (evq[i]) if (evq[i].ch == ch && evq[i].kind == kind) act.push_back(evq[i].cyc - t0);
    check($sformatf("%s.ch%0d.k%0d.count", nm, ch, kind), act.size(), exp_n);
    for (int i = 0; i < exp_n && i < act.size(); i++)
      check($sformatf("%s.ch%0d.k%0d[%0d]", nm, ch, kind, i), act[i], exp_offs[i]);
  endtask

  task automatic check_quiet_except(input string nm, input int ch_a, input int ch_b);
    int n = 0;
    foreach (evq[i]) if (evq[i].ch != ch_a && evq[i].ch != ch_b) n++;
    check($sformatf("%s.other_channels", nm), n, 0);
  endtask

  typedef struct {
    string name;
    int    ch;
    int    hold;
    int    n_acc;
    int    n_rep;
    int    rep_offs[12];
  } vec_t;

  vec_t vecs[6];

  initial begin
    int t0, b, c;
    int e_one[12];
    int e_rel[12];

    // name, channel, cycles held low, accepted presses, repeat pulses + offsets
    vecs[0] = '{"press_ch0",    0, 40, 1, 1, '{7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
    vecs[1] = '{"glitch_ch2",   2,  3, 0, 0, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
    vecs[2] = '{"repeat_ch3",   3, 60, 1, 9, '{7, 27, 32, 37, 42, 47, 52, 57, 62, 0, 0, 0}};
    vecs[3] = '{"norepeat_ch0", 0, 60, 1, 1, '{7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
    vecs[4] = '{"rep_cut_ch5",  5, 25, 1, 2, '{7, 27, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
    vecs[5] = '{"min_hold_ch4", 4,  4, 1, 1, '{7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};

    e_one = '{7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    // Reset state
    kif.key_in = '1;
    repeat (3) @(posedge clk);
    #2;
    check("reset.level",   int'(kif.key_level),   0);
    check("reset.press",   int'(kif.key_press),   0);
    check("reset.release", int'(kif.key_release), 0);
    check("reset.rep",     int'(kif.key_rep),     0);
    clr = 1'b0;
    evq.delete();
    wait_cycles(10);
    check("idle.no_events", evq.size(), 0);
    $display("txn reset/idle done");

    // Table-driven single-key holds
    for (int v = 0; v < 6; v++) begin
      t0 = cyc;
      evq.delete();
      kif.key_in[vecs[v].ch] = 1'b0;
      wait_cycles(vecs[v].hold);
      kif.key_in[vecs[v].ch] = 1'b1;
      wait_cycles(20);
      e_rel = '{default: 0};
      e_rel[0] = vecs[v].hold + 7;
      check_kind(vecs[v].name, vecs[v].ch, t0, 0, vecs[v].n_acc, e_one);
      check_kind(vecs[v].name, vecs[v].ch, t0, 1, vecs[v].n_acc, e_rel);
      check_kind(vecs[v].name, vecs[v].ch, t0, 2, vecs[v].n_rep, vecs[v].rep_offs);
      check_kind(vecs[v].name, vecs[v].ch, t0, 3, vecs[v].n_acc, e_one);
      check_kind(vecs[v].name, vecs[v].ch, t0, 4, vecs[v].n_acc, e_rel);
      check_quiet_except(vecs[v].name, vecs[v].ch, vecs[v].ch);
      $display("txn %s ch=%0d hold=%0d events=%0d", vecs[v].name, vecs[v].ch, vecs[v].hold, evq.size());
    end

    // Bounce on channel 1: 2-cycle toggles, then held low
    t0 = cyc;
    evq.delete();
    for (int k = 0; k < 6; k++) begin
      kif.key_in[1] = (k % 2 == 1) ? 1'b1 : 1'b0;
      wait_cycles(2);
    end
    b = cyc;
    kif.key_in[1] = 1'b0;
    wait_cycles(20);
    check_kind("bounce", 1, b, 0, 1, e_one);
    check_kind("bounce", 1, b, 2, 1, e_one);
    check_kind("bounce", 1, b, 1, 0, e_one);
    check_quiet_except("bounce", 1, 1);
    kif.key_in[1] = 1'b1;
    wait_cycles(20);
    $display("txn bounce ch=1 settle_offset=%0d", b - t0);

    // Simultaneous presses on channels 0 and 1
    t0 = cyc;
    evq.delete();
    kif.key_in[1:0] = 2'b00;
    wait_cycles(15);
    check_kind("simul", 0, t0, 0, 1, e_one);
    check_kind("simul", 1, t0, 0, 1, e_one);
    check_quiet_except("simul", 0, 1);
    kif.key_in[1:0] = 2'b11;
    wait_cycles(20);
    $display("txn simultaneous ch=0,1");

    // Reset while channel 4 is repeating, key kept held
    t0 = cyc;
    evq.delete();
    kif.key_in[4] = 1'b0;
    wait_cycles(35);
    check("rst_mid.level_before", int'(kif.key_level[4]), 1);
    #3;
    clr = 1'b1;
    #1;
    check("rst_mid.level",   int'(kif.key_level),   0);
    check("rst_mid.press",   int'(kif.key_press),   0);
    check("rst_mid.release", int'(kif.key_release), 0);
    check("rst_mid.rep",     int'(kif.key_rep),     0);
    wait_cycles(3);
    clr = 1'b0;
    c = cyc;
    evq.delete();
    wait_cycles(15);
    check_kind("rst_held", 4, c, 0, 1, e_one);
    check_kind("rst_held", 4, c, 2, 1, e_one);
    check_kind("rst_held", 4, c, 3, 1, e_one);
    check_quiet_except("rst_held", 4, 4);
    kif.key_in[4] = 1'b1;
    wait_cycles(20);
    $display("txn reset_during_repeat ch=4");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
